dio_irq_bank: RTL and testbench

DIO_IRQ_BANK -- requirements
Module: dio_irq_bank

---
 rtl/dio_irq_bank_pkg.sv | 20 ++
 rtl/dio_irq_bank_debounce.sv | 56 +++++
 rtl/dio_irq_bank.sv | 145 ++++++++++++++
 tb/tb_dio_irq_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dio_irq_bank_pkg.sv
// Shared constants for the DIO interrupt bank: bus width, register map
// offsets and the debounce-count reset value.
package dio_irq_bank_pkg;

  localparam int BUS_W  = 8;
  localparam int N_REGS = 7;

  typedef logic [BUS_W-1:0] bus_t;

  localparam bus_t OFF_DIN     = 8'd0;
  localparam bus_t OFF_DOUT_EN = 8'd1;
  localparam bus_t OFF_DOUT    = 8'd2;
  localparam bus_t OFF_RISE_EN = 8'd3;
  localparam bus_t OFF_FALL_EN = 8'd4;
  localparam bus_t OFF_STATUS  = 8'd5;
  localparam bus_t OFF_DEB_CNT = 8'd6;

  localparam bus_t DEB_CNT_RST = 8'd10;

endpackage

// File: rtl/dio_irq_bank_debounce.sv
// One DIO channel: two-flop synchroniser followed by a tick-driven debounce
// counter. The stable state flips once the input has disagreed with it for
// deb_cnt_i consecutive ticks; deb_cnt_i == 0 bypasses the counter.
module dio_debounce
  import dio_irq_bank_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  input  logic tick_i,
  input  bus_t deb_cnt_i,
  input  logic cnt_clr_i,
  output logic stable_o
);

  logic sync1_q, sync2_q;
  logic stable_q, stable_d;
  bus_t cnt_q, cnt_d;

  // Next stable state and counter value.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (deb_cnt_i == '0) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else if (cnt_clr_i || (sync2_q == stable_q)) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if ((cnt_q + 8'd1) >= deb_cnt_i) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Synchroniser, stable state and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/dio_irq_bank.sv
// DIO bank on the GPMC MISC bus: debounced inputs with edge-triggered
// sticky status and a level interrupt, plus enable-gated registered outputs.
module dio_irq_bank
  import dio_irq_bank_pkg::*;
#(
  parameter int   N_CH      = 4,
  parameter int   TICK_DIV  = 24,
  parameter bus_t BASE_ADDR = 8'h10,
  parameter bit   INV_IN    = 1'b1
) (
  input  logic            fpga_clk,
  input  logic            sys_reset_n,
  input  logic            gpmc_cs_n,
  input  logic            gpmc_we_n,
  input  logic            gpmc_oe_n,
  input  logic [7:0]      sa,
  inout  wire  [7:0]      sd,
  input  logic [N_CH-1:0] dio_in,
  output logic [N_CH-1:0] dio_out,
  output logic            irq_out
);

  localparam bus_t PRE_LAST = bus_t'(TICK_DIV - 1);

  bus_t            pre_q, pre_d;
  logic            tick;
  bus_t            off;
  logic            in_bank, wr_hit, rd_hit, wr_stb, wr_hit_q;
  logic [N_CH-1:0] wdata;
  bus_t            rdata;
  logic            cnt_clr;

  logic [N_CH-1:0] stable, set_evt;
  logic [N_CH-1:0] dout_en_q, dout_en_d;
  logic [N_CH-1:0] dout_q, dout_d;
  logic [N_CH-1:0] rise_en_q, rise_en_d;
  logic [N_CH-1:0] fall_en_q, fall_en_d;
  logic [N_CH-1:0] status_q, status_d;
  logic [N_CH-1:0] stb_prev_q;
  logic [N_CH-1:0] dio_out_q, dio_out_d;
  bus_t            deb_cnt_q, deb_cnt_d;
  logic            irq_q, irq_d;

  // Address decode; offsets below BASE_ADDR wrap high and fall outside the bank.
  assign off     = sa - BASE_ADDR;
  assign in_bank = off < bus_t'(N_REGS);
  assign wr_hit  = !gpmc_cs_n && !gpmc_we_n && in_bank;
  assign rd_hit  = sys_reset_n && !gpmc_cs_n && !gpmc_oe_n && in_bank;
  assign wr_stb  = wr_hit && !wr_hit_q;
  assign wdata   = sd[N_CH-1:0];
  assign cnt_clr = wr_stb && (off == OFF_DEB_CNT);

  // Debounce tick prescaler: counts 0..TICK_DIV-1, tick on the wrap.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + 8'd1;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    dio_debounce u_deb (
      .clk_i     (fpga_clk),
      .rst_ni    (sys_reset_n),
      .din_i     (dio_in[g] ^ INV_IN),
      .tick_i    (tick),
      .deb_cnt_i (deb_cnt_q),
      .cnt_clr_i (cnt_clr),
      .stable_o  (stable[g])
    );
  end

  assign set_evt = (stable & ~stb_prev_q & rise_en_q) |
                   (~stable & stb_prev_q & fall_en_q);

  // Register-file next state; a status set event overrides a same-cycle clear.
  always_comb begin
    dout_en_d = dout_en_q;
    dout_d    = dout_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    deb_cnt_d = deb_cnt_q;
    if (wr_stb) begin
      case (off)
        OFF_DOUT_EN: dout_en_d = wdata;
        OFF_DOUT:    dout_d    = wdata;
        OFF_RISE_EN: rise_en_d = wdata;
        OFF_FALL_EN: fall_en_d = wdata;
        OFF_STATUS:  status_d  = status_q & ~wdata;
        OFF_DEB_CNT: deb_cnt_d = sd;
        default: ;
      endcase
    end
    status_d  = status_d | set_evt;
    dio_out_d = dout_q & dout_en_q;
    irq_d     = |status_q;
  end

  // Read-back mux; unused upper bits read as zero.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_DIN:     rdata = bus_t'(stable);
      OFF_DOUT_EN: rdata = bus_t'(dout_en_q);
      OFF_DOUT:    rdata = bus_t'(dout_q);
      OFF_RISE_EN: rdata = bus_t'(rise_en_q);
      OFF_FALL_EN: rdata = bus_t'(fall_en_q);
      OFF_STATUS:  rdata = bus_t'(status_q);
      OFF_DEB_CNT: rdata = deb_cnt_q;
      default:     rdata = '0;
    endcase
  end

  assign sd = rd_hit ? rdata : 'z;

  // Control and register state.
  always_ff @(posedge fpga_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      pre_q      <= '0;
      wr_hit_q   <= 1'b0;
      dout_en_q  <= '0;
      dout_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      stb_prev_q <= '0;
      deb_cnt_q  <= DEB_CNT_RST;
      dio_out_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      wr_hit_q   <= wr_hit;
      dout_en_q  <= dout_en_d;
      dout_q     <= dout_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      stb_prev_q <= stable;
      deb_cnt_q  <= deb_cnt_d;
      dio_out_q  <= dio_out_d;
      irq_q      <= irq_d;
    end
  end

  assign dio_out = dio_out_q;
  assign irq_out = irq_q;

endmodule

// File: tb/tb_dio_irq_bank.sv
// Directed bench for dio_irq_bank: register table plus timed sequences for
// debounce, interrupt, write-strobe and reset behaviour.
module tb_dio_irq_bank;

  localparam logic [7:0] BASE = 8'h10;
  localparam int         NCH  = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cs_n = 1'b1, we_n = 1'b1, oe_n = 1'b1;
  logic [7:0]     sa = 8'h00;
  logic [7:0]     sd_drv = 8'h00;
  logic           sd_oe = 1'b0;
  logic [NCH-1:0] dio_in = '1;
  logic [NCH-1:0] dio_out;
  logic           irq_out;
  wire  [7:0]     sd;

  int n_vec = 0;
  int n_err = 0;

  assign sd = sd_oe ? sd_drv : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (sd[i]);
  end

  always #5 clk = ~clk;

  dio_irq_bank #(.N_CH(NCH), .TICK_DIV(24), .BASE_ADDR(BASE), .INV_IN(1'b1)) dut (
    .fpga_clk    (clk),
    .sys_reset_n (rst_n),
    .gpmc_cs_n   (cs_n),
    .gpmc_we_n   (we_n),
    .gpmc_oe_n   (oe_n),
    .sa          (sa),
    .sd          (sd),
    .dio_in      (dio_in),
    .dio_out     (dio_out),
    .irq_out     (irq_out)
  );

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int len);
    sa = a; sd_drv = d; sd_oe = 1'b1; cs_n = 1'b0; we_n = 1'b0;
    repeat (len) @(negedge clk);
    cs_n = 1'b1; we_n = 1'b1; sd_oe = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    sa = a; cs_n = 1'b0; oe_n = 1'b0;
    #1 d = sd;
    cs_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [24];
    logic [7:0] r;
    int         cyc;
    bit         found;

    tbl[0]  = '{0, BASE + 8'd0, 8'h00};
    tbl[1]  = '{0, BASE + 8'd1, 8'h00};
    tbl[2]  = '{0, BASE + 8'd2, 8'h00};
    tbl[3]  = '{0, BASE + 8'd3, 8'h00};
    tbl[4]  = '{0, BASE + 8'd4, 8'h00};
    tbl[5]  = '{0, BASE + 8'd5, 8'h00};
    tbl[6]  = '{0, BASE + 8'd6, 8'h0A};
    tbl[7]  = '{1, BASE + 8'd3, 8'hFF};
    tbl[8]  = '{0, BASE + 8'd3, 8'h0F};
    tbl[9]  = '{1, BASE + 8'd4, 8'hA5};
    tbl[10] = '{0, BASE + 8'd4, 8'h05};
    tbl[11] = '{1, BASE + 8'd6, 8'h37};
    tbl[12] = '{0, BASE + 8'd6, 8'h37};
    tbl[13] = '{1, BASE + 8'd0, 8'hFF};
    tbl[14] = '{0, BASE + 8'd0, 8'h00};
    tbl[15] = '{1, BASE + 8'd5, 8'hFF};
    tbl[16] = '{0, BASE + 8'd5, 8'h00};
    tbl[17] = '{0, BASE + 8'd7, 8'hFF};
    tbl[18] = '{0, BASE - 8'd1, 8'hFF};
    tbl[19] = '{1, BASE + 8'd3, 8'h01};
    tbl[20] = '{1, BASE + 8'd4, 8'h00};
    tbl[21] = '{1, BASE + 8'd6, 8'h0A};
    tbl[22] = '{1, BASE + 8'd1, 8'h05};
    tbl[23] = '{0, BASE + 8'd1, 8'h05};

    // Reset state
    #12;
    chk("reset dio_out", dio_out, 0);
    chk("reset irq_out", irq_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Register table
    for (int i = 0; i < 24; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data, 1);
      else begin
        rd(tbl[i].addr, r);
        chk($sformatf("reg vec %0d addr 0x%0h", i, tbl[i].addr), r, tbl[i].data);
      end
    end

    // Long write strobe commits once; outputs gated by enable
    wr(BASE + 8'd2, 8'h0F, 10);
    chk("dio_out gated", dio_out, 4'b0101);
    rd(BASE + 8'd7, r);
    chk("offset 7 hiZ", r, 8'hFF);

    // Debounced rise on ch0 with RISE_EN=1, STATUS polled every cycle
    dio_in[0] = 1'b0;
    sa = BASE + 8'd5; cs_n = 1'b0; oe_n = 1'b0;
    cyc = 0; found = 1'b0;
    while (!found && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
      if (sd == 8'h01) found = 1'b1;
    end
    chk("rise debounce in window", (found && cyc >= 215 && cyc <= 250), 1);
    chk("irq lags status", irq_out, 0);
    @(negedge clk); #1;
    chk("irq one cycle after status", irq_out, 1);
    cs_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
    rd(BASE + 8'd0, r);
    chk("DIN after rise", r, 8'h01);

    // W1C of STATUS[0] drops irq two cycles after the write
    sa = BASE + 8'd5; sd_drv = 8'h01; sd_oe = 1'b1; cs_n = 1'b0; we_n = 1'b0;
    @(negedge clk); #1;
    chk("irq still set after W1C edge", irq_out, 1);
    cs_n = 1'b1; we_n = 1'b1; sd_oe = 1'b0;
    @(negedge clk); #1;
    chk("irq cleared after W1C", irq_out, 0);
    @(negedge clk);

    // 200-cycle glitch is rejected
    dio_in[0] = 1'b1;
    repeat (200) @(negedge clk);
    dio_in[0] = 1'b0;
    repeat (100) @(negedge clk);
    rd(BASE + 8'd0, r);
    chk("DIN after glitch", r, 8'h01);

    // DEB_CNT=0 bypass: DIN follows 3 cycles after the edge
    wr(BASE + 8'd6, 8'h00, 1);
    wr(BASE + 8'd4, 8'h02, 1);
    sa = BASE + 8'd0; cs_n = 1'b0; oe_n = 1'b0;
    dio_in[1] = 1'b0;
    @(negedge clk); #1;
    chk("bypass +1", sd, 8'h01);
    @(negedge clk); #1;
    chk("bypass +2", sd, 8'h01);
    @(negedge clk); #1;
    chk("bypass +3", sd, 8'h03);
    cs_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);

    // Fall on ch1 coincides with a long W1C of STATUS[1]: set wins
    dio_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    wr(BASE + 8'd5, 8'h02, 10);
    rd(BASE + 8'd5, r);
    chk("set beats W1C", r, 8'h02);
    chk("irq from ch1 fall", irq_out, 1);
    wr(BASE + 8'd5, 8'h01, 1);
    rd(BASE + 8'd5, r);
    chk("W1C other bit only", r, 8'h02);
    wr(BASE + 8'd4, 8'h00, 1);
    rd(BASE + 8'd5, r);
    chk("FALL_EN clear keeps status", r, 8'h02);

    // Reset mid-count
    wr(BASE + 8'd6, 8'h0A, 1);
    dio_in[2] = 1'b0;
    repeat (100) @(negedge clk);
    chk("dio_out before reset", dio_out, 4'b0101);
    chk("irq before reset", irq_out, 1);
    sa = BASE + 8'd6; cs_n = 1'b0; oe_n = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset dio_out", dio_out, 0);
    chk("async reset irq_out", irq_out, 0);
    chk("sd hiZ in reset", sd, 8'hFF);
    cs_n = 1'b1; oe_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    rd(BASE + 8'd0, r);
    chk("partial count discarded", r, 8'h00);
    rd(BASE + 8'd6, r);
    chk("DEB_CNT reset value", r, 8'h0A);
    repeat (150) @(negedge clk);
    rd(BASE + 8'd0, r);
    chk("DIN after re-debounce", r, 8'h05);
    rd(BASE + 8'd5, r);
    chk("no status after release", r, 8'h00);
    chk("no irq after release", irq_out, 0);
    chk("dio_out after reset", dio_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
